// File: rtl/wb_sram16_pkg.sv
// Shared types and Wishbone cycle/burst-type encodings for the 16-bit SRAM bridge.
package wb_sram16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2
   } state_e;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

endpackage

// File: rtl/wb_burst_adr_next.sv
// Next beat address of a Wishbone incrementing burst: linear modulo 2^ADDRESS,
// wrap4/8/16 keep the upper bits and roll the low 2/3/4 bits.
module wb_burst_adr_next
   import wb_sram16_pkg::*;
#(
   parameter int ADDRESS = 18
) (
   input  logic [ADDRESS-1:0] adr_i,
   input  logic [1:0]         bte_i,
   output logic [ADDRESS-1:0] adr_o
);

   always_comb begin
      adr_o = adr_i + ADDRESS'(1);
      case (bte_i)
         BTE_WRAP4:  adr_o = {adr_i[ADDRESS-1:2], adr_i[1:0] + 2'd1};
         BTE_WRAP8:  adr_o = {adr_i[ADDRESS-1:3], adr_i[2:0] + 3'd1};
         BTE_WRAP16: adr_o = {adr_i[ADDRESS-1:4], adr_i[3:0] + 4'd1};
         default: ;
      endcase
   end

endmodule

// File: rtl/wb_sram16_bridge.sv
// Wishbone B3 32-bit slave to 16-bit asynchronous SRAM, low half then high half.
// Define WB_SRAM16_WRAP_EN to honour wrap4/8/16 bursts; otherwise they end after one beat.
module wb_sram16_bridge
   import wb_sram16_pkg::*;
#(
   parameter int ADDRESS = 18,
   parameter int WAITS   = 1
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               wb_cyc_i,
   input  logic               wb_stb_i,
   input  logic               wb_we_i,
   input  logic [2:0]         wb_cti_i,
   input  logic [1:0]         wb_bte_i,
   input  logic [ADDRESS-1:0] wb_adr_i,
   input  logic [3:0]         wb_sel_i,
   input  logic [31:0]        wb_dat_i,
   output logic [31:0]        wb_dat_o,
   output logic               wb_ack_o,
   output logic [ADDRESS:0]   sram_adr_o,
   output logic [15:0]        sram_dat_o,
   input  logic [15:0]        sram_dat_i,
   output logic               sram_doe_o,
   output logic               sram_ce_no,
   output logic               sram_oe_no,
   output logic               sram_we_no,
   output logic [1:0]         sram_be_no
);

   localparam int            CW       = (WAITS > 1) ? $clog2(WAITS) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAITS - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [ADDRESS-1:0] adr_q, adr_d;
   logic               we_q, we_d;
   logic [3:0]         sel_q, sel_d;
   logic [31:0]        wdat_q, wdat_d;
   logic [2:0]         cti_q, cti_d;
   logic [1:0]         bte_q, bte_d;
   logic               ack_q, ack_d;
   logic [31:0]        dat_q, dat_d;
   logic [ADDRESS:0]   sram_adr_q, sram_adr_d;
   logic [15:0]        sram_dat_q, sram_dat_d;
   logic               doe_q, doe_d;
   logic               ce_n_q, ce_n_d;
   logic               oe_n_q, oe_n_d;
   logic               we_n_q, we_n_d;
   logic [1:0]         be_n_q, be_n_d;

   logic [ADDRESS-1:0] adr_nxt;
   logic               burst_ok;
   logic               half_done;
   logic               is_hi;
   logic [1:0]         sel_half;

   wb_burst_adr_next #(.ADDRESS(ADDRESS)) u_adr_next (
      .adr_i (adr_q),
      .bte_i (bte_q),
      .adr_o (adr_nxt)
   );

`ifdef WB_SRAM16_WRAP_EN
   assign burst_ok = 1'b1;
`else
   assign burst_ok = (bte_q == BTE_LINEAR);
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      adr_d      = adr_q;
      we_d       = we_q;
      sel_d      = sel_q;
      wdat_d     = wdat_q;
      cti_d      = cti_q;
      bte_d      = bte_q;
      ack_d      = 1'b0;
      dat_d      = dat_q;
      sram_adr_d = sram_adr_q;
      sram_dat_d = sram_dat_q;
      ce_n_d     = 1'b1;
      oe_n_d     = 1'b1;
      we_n_d     = 1'b1;
      be_n_d     = 2'b11;
      doe_d      = 1'b0;
      is_hi      = 1'b0;
      sel_half   = 2'b00;
      half_done  = (cnt_q == '0);

      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i && !ack_q) begin
               adr_d  = wb_adr_i;
               we_d   = wb_we_i;
               sel_d  = wb_sel_i;
               wdat_d = wb_dat_i;
               cti_d  = wb_cti_i;
               bte_d  = wb_bte_i;
               cnt_d  = CNT_LOAD;
               if (!wb_we_i || wb_sel_i[1:0] != 2'b00) begin
                  state_d = ST_LO;
               end else if (wb_sel_i[3:2] != 2'b00) begin
                  state_d = ST_HI;
               end else begin
                  ack_d = 1'b1;
               end
            end
         end
         ST_LO: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (!half_done) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               cnt_d = CNT_LOAD;
               if (!we_q) dat_d[15:0] = sram_dat_i;
               if (we_q && sel_q[3:2] == 2'b00) begin
                  ack_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_HI;
               end
            end
         end
         ST_HI: begin
            if (!wb_cyc_i) begin
               state_d = ST_IDLE;
            end else if (!half_done) begin
               cnt_d = cnt_q - CW'(1);
            end else begin
               cnt_d = CNT_LOAD;
               ack_d = 1'b1;
               if (!we_q) dat_d[31:16] = sram_dat_i;
               // The master still presents the cti of the beat being acked, so an END
               // here stops the speculative fetch before it touches the SRAM.
               if (wb_stb_i && !we_q && burst_ok &&
                   cti_q == CTI_INCR && wb_cti_i == CTI_INCR) begin
                  state_d = ST_LO;
                  adr_d   = adr_nxt;
                  cti_d   = wb_cti_i;
                  bte_d   = wb_bte_i;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // SRAM pins are registered from the state being entered.
      if (state_d != ST_IDLE) begin
         is_hi      = (state_d == ST_HI);
         sel_half   = is_hi ? sel_d[3:2] : sel_d[1:0];
         ce_n_d     = 1'b0;
         sram_adr_d = {adr_d, is_hi};
         if (we_d) begin
            doe_d      = 1'b1;
            we_n_d     = 1'b0;
            be_n_d     = ~sel_half;
            sram_dat_d = is_hi ? wdat_d[31:16] : wdat_d[15:0];
         end else begin
            oe_n_d = 1'b0;
            be_n_d = 2'b00;
         end
      end
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
         sram_adr_q <= '0;
         sram_dat_q <= '0;
         doe_q      <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         be_n_q     <= 2'b11;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         dat_q      <= dat_d;
         sram_adr_q <= sram_adr_d;
         sram_dat_q <= sram_dat_d;
         doe_q      <= doe_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         be_n_q     <= be_n_d;
      end
   end

   // Request fields are only consumed outside IDLE, after being loaded.
   always_ff @(posedge wb_clk_i) begin
      adr_q  <= adr_d;
      we_q   <= we_d;
      sel_q  <= sel_d;
      wdat_q <= wdat_d;
      cti_q  <= cti_d;
      bte_q  <= bte_d;
   end

   assign wb_dat_o   = dat_q;
   assign wb_ack_o   = ack_q;
   assign sram_adr_o = sram_adr_q;
   assign sram_dat_o = sram_dat_q;
   assign sram_doe_o = doe_q;
   assign sram_ce_no = ce_n_q;
   assign sram_oe_no = oe_n_q;
   assign sram_we_no = we_n_q;
   assign sram_be_no = be_n_q;

endmodule

// File: tb/tb_wb_sram16_bridge.sv
// Directed bench for wb_sram16_bridge: WAITS=1 instance for most sequences, WAITS=3 for the abort case.
module tb_wb_sram16_bridge;
   import wb_sram16_pkg::*;

   localparam int AW = 8;

   typedef struct {
      bit          w;
      logic [7:0]  a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
      int          lat;
      int          wec;
      int          cec;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic cyc, stb, we;
   logic [2:0] cti;
   logic [1:0] bte;
   logic [AW-1:0] adr;
   logic [3:0] sel;
   logic [31:0] wdat;

   logic [31:0] d1_dat, d3_dat;
   logic d1_ack, d3_ack;
   logic [AW:0] d1_sadr, d3_sadr;
   logic [15:0] d1_sdo, d3_sdo, d1_sdi, d3_sdi;
   logic d1_doe, d3_doe, d1_ce, d3_ce, d1_oe, d3_oe, d1_we, d3_we;
   logic [1:0] d1_be, d3_be;

   logic [15:0] mem1 [0:511];
   logic [15:0] mem3 [0:511];
   bit mem_init;
   int we1_cyc, ce1_cyc, touched12, we23_cnt, ack1_cnt, ack3_cnt;
   logic [1:0] be23;

   int n_pass, n_total;
   vec_t tbl [11];
   logic [7:0]  badr [4];
   logic [31:0] bdat [4];
   int          bedge [4];
   logic        bce [4];
   int          back;

   always #5 clk = ~clk;

   wb_sram16_bridge #(.ADDRESS(AW), .WAITS(1)) dut1 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_cti_i(cti), .wb_bte_i(bte), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
      .wb_dat_o(d1_dat), .wb_ack_o(d1_ack), .sram_adr_o(d1_sadr), .sram_dat_o(d1_sdo),
      .sram_dat_i(d1_sdi), .sram_doe_o(d1_doe), .sram_ce_no(d1_ce), .sram_oe_no(d1_oe),
      .sram_we_no(d1_we), .sram_be_no(d1_be));

   wb_sram16_bridge #(.ADDRESS(AW), .WAITS(3)) dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
      .wb_cti_i(cti), .wb_bte_i(bte), .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
      .wb_dat_o(d3_dat), .wb_ack_o(d3_ack), .sram_adr_o(d3_sadr), .sram_dat_o(d3_sdo),
      .sram_dat_i(d3_sdi), .sram_doe_o(d3_doe), .sram_ce_no(d3_ce), .sram_oe_no(d3_oe),
      .sram_we_no(d3_we), .sram_be_no(d3_be));

   assign d1_sdi = mem1[d1_sadr];
   assign d3_sdi = mem3[d3_sadr];

   // SRAM models and activity counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (!mem_init) begin
         for (int i = 0; i < 512; i++) begin
            mem1[i] = 16'h5A00 | 16'(i % 256);
            mem3[i] = 16'h5A00 | 16'(i % 256);
         end
         mem1[20] = 16'h1234;
         mem1[21] = 16'hABCD;
         mem_init = 1'b1;
      end
      if (!d1_ce) ce1_cyc++;
      if (!d1_ce && !d1_we) begin
         we1_cyc++;
         if (!d1_be[0]) mem1[d1_sadr][7:0]  = d1_sdo[7:0];
         if (!d1_be[1]) mem1[d1_sadr][15:8] = d1_sdo[15:8];
         if (d1_sadr == 9'd23) begin
            we23_cnt++;
            be23 = d1_be;
         end
      end
      if (!d1_ce && d1_sadr[AW:1] == 8'd12) touched12++;
      if (d1_ack) ack1_cnt++;
      if (!d3_ce && !d3_we) begin
         if (!d3_be[0]) mem3[d3_sadr][7:0]  = d3_sdo[7:0];
         if (!d3_be[1]) mem3[d3_sadr][15:8] = d3_sdo[15:8];
      end
      if (d3_ack) ack3_cnt++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic run_single(input bit w, input logic [7:0] a, input logic [3:0] s,
                             input logic [31:0] d, output logic [31:0] rd, output int lat);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
      cti = CTI_CLASSIC; bte = BTE_LINEAR;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         if (d1_ack) begin
            lat = i;
            break;
         end
      end
      rd  = d1_dat;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic run_burst(input logic [1:0] bt, input int nb);
      int e, k;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; bte = bt; adr = badr[0];
      cti = (nb > 1) ? CTI_INCR : CTI_END;
      e = 0; k = 0;
      while (k < nb && e < 40) begin
         @(posedge clk); #1;
         e++;
         if (d1_ack) begin
            bdat[k] = d1_dat; bedge[k] = e; bce[k] = d1_ce;
            k++;
            if (k < nb) begin
               adr = badr[k];
               cti = (k == nb - 1) ? CTI_END : CTI_INCR;
            end
         end
      end
      back = k;
      cyc = 1'b0; stb = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int lat, w0, c0, a0, t0;
      logic [31:0] exp_w [4];
      int exp_gap, exp_ce_mid;

      tbl[0]  = '{1'b0, 8'd10,  4'hF, 32'h0,        32'hABCD1234, 3, 0, 2};
      tbl[1]  = '{1'b1, 8'd11,  4'hC, 32'hDEADBEEF, 32'h0,        2, 1, 1};
      tbl[2]  = '{1'b0, 8'd11,  4'hF, 32'h0,        32'hDEAD5A16, 3, 0, 2};
      tbl[3]  = '{1'b1, 8'd3,   4'h3, 32'h1111CAFE, 32'h0,        2, 1, 1};
      tbl[4]  = '{1'b0, 8'd3,   4'hF, 32'h0,        32'h5A07CAFE, 3, 0, 2};
      tbl[5]  = '{1'b1, 8'd2,   4'h6, 32'h77665544, 32'h0,        3, 2, 2};
      tbl[6]  = '{1'b0, 8'd2,   4'hF, 32'h0,        32'h5A665504, 3, 0, 2};
      tbl[7]  = '{1'b1, 8'd255, 4'hF, 32'h0BADF00D, 32'h0,        3, 2, 2};
      tbl[8]  = '{1'b0, 8'd255, 4'hF, 32'h0,        32'h0BADF00D, 3, 0, 2};
      tbl[9]  = '{1'b1, 8'd5,   4'h0, 32'hFFFFFFFF, 32'h0,        1, 0, 0};
      tbl[10] = '{1'b0, 8'd5,   4'hF, 32'h0,        32'h5A0B5A0A, 3, 0, 2};

      n_pass = 0; n_total = 0;
      rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = CTI_CLASSIC; bte = BTE_LINEAR;
      adr = '0; sel = 4'h0; wdat = '0;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ctl1", {d1_ce, d1_oe, d1_we, d1_be, d1_doe, d1_ack}, 7'b1111100);
      check("reset_ctl3", {d3_ce, d3_oe, d3_we, d3_be, d3_doe, d3_ack}, 7'b1111100);
      check("reset_dat", d1_dat, 32'h0);
      check("reset_sadr", {23'd0, d1_sadr}, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // linear read burst, words 8..11
      badr[0] = 8'd8; badr[1] = 8'd9; badr[2] = 8'd10; badr[3] = 8'd11;
      t0 = touched12; a0 = ack1_cnt;
      run_burst(BTE_LINEAR, 4);
      check("lin_beats", back, 4);
      exp_w[0] = 32'h5A115A10; exp_w[1] = 32'h5A135A12;
      exp_w[2] = 32'hABCD1234; exp_w[3] = 32'h5A175A16;
      check("lin_first_ack", bedge[0], 3);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("lin_dat%0d", k), bdat[k], exp_w[k]);
         check($sformatf("lin_ce_at_ack%0d", k), bce[k], (k < 3) ? 1'b0 : 1'b1);
         if (k > 0) check($sformatf("lin_gap%0d", k), bedge[k] - bedge[k-1], 2);
      end
      check("lin_no_word12", touched12 - t0, 0);
      check("lin_ack_count", ack1_cnt - a0, 4);

      // wrap4 burst from word 6
      badr[0] = 8'd6; badr[1] = 8'd7; badr[2] = 8'd4; badr[3] = 8'd5;
      exp_w[0] = 32'h5A0D5A0C; exp_w[1] = 32'h5A0F5A0E;
      exp_w[2] = 32'h5A095A08; exp_w[3] = 32'h5A0B5A0A;
`ifdef WB_SRAM16_WRAP_EN
      exp_gap = 2; exp_ce_mid = 0;
`else
      exp_gap = 4; exp_ce_mid = 1;
`endif
      run_burst(BTE_WRAP4, 4);
      check("wrap_beats", back, 4);
      check("wrap_ce_after_first", bce[0], exp_ce_mid[0]);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("wrap_dat%0d", k), bdat[k], exp_w[k]);
         if (k > 0) check($sformatf("wrap_gap%0d", k), bedge[k] - bedge[k-1], exp_gap);
      end

      // single transactions
      for (int i = 0; i < 11; i++) begin
         w0 = we1_cyc; c0 = ce1_cyc;
         run_single(tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d, rd, lat);
         check($sformatf("v%0d_lat", i), lat, tbl[i].lat);
         if (!tbl[i].w) check($sformatf("v%0d_rdat", i), rd, tbl[i].exp);
         check($sformatf("v%0d_ack_pulse", i), d1_ack, 1'b0);
         check($sformatf("v%0d_deselect", i), d1_ce, 1'b1);
         check($sformatf("v%0d_we_cycles", i), we1_cyc - w0, tbl[i].wec);
         check($sformatf("v%0d_ce_cycles", i), ce1_cyc - c0, tbl[i].cec);
      end
      check("wr11_lo_untouched", mem1[22], 16'h5A16);
      check("wr11_hi_written", mem1[23], 16'hDEAD);
      check("wr11_be", be23, 2'b00);
      check("wr11_we_pulses", we23_cnt, 1);

      // WAITS=3: abort in the second LO cycle, then a clean read
      repeat (3) @(negedge clk);
      a0 = ack3_cnt;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd9; sel = 4'hF; cti = CTI_CLASSIC; bte = BTE_LINEAR;
      @(posedge clk); @(posedge clk); #1;
      check("w3_lo_active", d3_ce, 1'b0);
      check("w3_lo_adr", d3_sadr, 9'd18);
      cyc = 1'b0; stb = 1'b0;
      @(posedge clk); #1;
      check("w3_abort_ce", d3_ce, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      check("w3_abort_noack", ack3_cnt - a0, 0);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd9; sel = 4'hF;
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (d3_ack) begin
            lat = i;
            break;
         end
      end
      rd = d3_dat;
      cyc = 1'b0; stb = 1'b0;
      check("w3_read_lat", lat, 7);
      check("w3_read_dat", rd, 32'h5A135A12);
      repeat (4) @(posedge clk);

      // async reset in the middle of HI
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'd8; sel = 4'hF;
      @(posedge clk); @(posedge clk); #1;
      check("rst_in_hi", d1_sadr, 9'd17);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_ctl", {d1_ce, d1_oe, d1_we, d1_be, d1_doe, d1_ack}, 7'b1111100);
      check("rst_mid_dat", d1_dat, 32'h0);
      check("rst_mid_sadr", d1_sadr, 9'd0);
      check("rst_mid_sdo", d1_sdo, 16'h0);
      cyc = 1'b0; stb = 1'b0;
      a0 = ack1_cnt;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("rst_no_ack", ack1_cnt - a0, 0);
      check("rst_idle_ce", d1_ce, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
